// File: rtl/serial_negate_32b_pkg.sv
// Shared types and constants for the bit-serial one's/two's complement negator.
package serial_negate_32b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic MODE_FLIP = 1'b0;
  localparam logic MODE_NEG  = 1'b1;

endpackage

// File: rtl/serial_negate_32b_neg_bit_cell.sv
// One-bit negation cell: flips every bit in flip mode; in negate mode copies
// bits up to and including the first 1, then flips the remainder.
module neg_bit_cell
  import serial_negate_32b_pkg::*;
(
  input  logic bit_in,
  input  logic mode,
  input  logic seen_one,
  output logic res_bit,
  output logic seen_one_next
);

  always_comb begin
    res_bit       = ~bit_in;
    seen_one_next = seen_one;
    if (mode == MODE_NEG) begin
      res_bit       = seen_one ? ~bit_in : bit_in;
      seen_one_next = seen_one | bit_in;
    end
  end

endmodule

// File: rtl/serial_negate_32b.sv
// Bit-serial negator, one result bit per clock, LSB first.
// Define SERIAL_NEGATE_OVF_EN to add the ovf port flagging negation of the most negative value.
module serial_negate_32b
  import serial_negate_32b_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_number,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_number,
  output logic             busy
`ifdef SERIAL_NEGATE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_one_q, seen_one_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cell_res, cell_seen;

  neg_bit_cell u_cell (
    .bit_in        (operand_q[cnt_q]),
    .mode          (mode_q),
    .seen_one      (seen_one_q),
    .res_bit       (cell_res),
    .seen_one_next (cell_seen)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_one_d = seen_one_q;
    mode_d     = mode_q;
    operand_d  = operand_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_d  = in_number;
          mode_d     = mode;
          cnt_d      = '0;
          seen_one_d = 1'b0;
          result_d   = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        result_d[cnt_q] = cell_res;
        seen_one_d      = cell_seen;
        cnt_d           = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seen_one_q <= 1'b0;
      mode_q     <= MODE_FLIP;
      operand_q  <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_one_q <= seen_one_d;
      mode_q     <= mode_d;
      operand_q  <= operand_d;
      result_q   <= result_d;
    end
  end

  // The partially built result is masked so only a finished value is ever visible.
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign out_valid  = (state_q == DONE);
  assign out_number = (state_q == DONE) ? result_q : '0;

`ifdef SERIAL_NEGATE_OVF_EN
  assign ovf = (state_q == DONE) && (mode_q == MODE_NEG) &&
               (operand_q == {1'b1, {(WIDTH-1){1'b0}}});
`endif

endmodule

// File: tb/tb_serial_negate_32b.sv
// Self-checking bench for serial_negate_32b against an arithmetic reference model.
module tb_serial_negate_32b;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_number = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_number;
`ifdef SERIAL_NEGATE_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_negate_32b #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_number  (in_number),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_number (out_number),
    .busy       (busy)
`ifdef SERIAL_NEGATE_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] x, input logic m);
    return m ? (W'(0) - x) : ~x;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic m);
    return m && (x == 32'h8000_0000);
  endfunction

  // Called at a negedge; offers an operand and returns one edge after acceptance.
  task automatic do_accept(input logic [W-1:0] n, input logic m, output bit ok);
    int guard = 0;
    in_valid  = 1'b1;
    in_number = n;
    mode      = m;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (in_ready === 1'b1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_number = $urandom;
    mode      = 1'($urandom);
  endtask

  // Counts rising edges until out_valid is seen at a negedge (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_number !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b busy=%b num=%h, expected 0 0 0",
               out_valid, busy, out_number);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] nums[6];
    logic         modes[6];
    bit           ok;
    int           edges;
    nums[0] = 32'h0000_0000; modes[0] = 1'b0;
    nums[1] = 32'h0000_0001; modes[1] = 1'b1;
    nums[2] = 32'h0000_0000; modes[2] = 1'b1;
    nums[3] = 32'h0000_0A50; modes[3] = 1'b1;
    nums[4] = 32'h8000_0000; modes[4] = 1'b1;
    nums[5] = 32'h7FFF_FFFF; modes[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_accept(nums[i], modes[i], ok);
      wait_done(edges);
      checks++;
      if (!ok || edges != W) begin
        errors++;
        $display("[TB] FAIL vec%0d_latency: got %0d edges (accepted=%b), expected %0d",
                 i, edges, ok, W);
      end
      checks++;
      if (out_number !== ref_result(nums[i], modes[i])) begin
        errors++;
        $display("[TB] FAIL vec%0d_result: got %h expected %h", i, out_number,
                 ref_result(nums[i], modes[i]));
      end
`ifdef SERIAL_NEGATE_OVF_EN
      checks++;
      if (ovf !== ref_ovf(nums[i], modes[i])) begin
        errors++;
        $display("[TB] FAIL vec%0d_ovf: got %b expected %b", i, ovf, ref_ovf(nums[i], modes[i]));
      end
`endif
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL vec%0d_release: got valid=%b ready=%b expected 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] n   = 32'h5A5A_1234;
    logic         m   = 1'b1;
    logic [W-1:0] exp = ref_result(n, m);
    bit           ok;
    int           edges;
    do_accept(n, m, ok);
    in_valid  = 1'b1;
    in_number = ~n;
    mode      = 1'b0;
    wait_done(edges);
    for (int c = 0; c < 5; c++) begin
      in_number = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_number !== exp) begin
        errors++;
        $display("[TB] FAIL hold_c%0d: got valid=%b num=%h expected 1 %h",
                 c, out_valid, out_number, exp);
      end
    end
    in_valid = 1'b0;
    consume();
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int edges;
    do_accept($urandom, 1'b1, ok);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_number !== '0) begin
      errors++;
      $display("[TB] FAIL shift_abort: got valid=%b busy=%b num=%h expected 0 0 0",
               out_valid, busy, out_number);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL shift_abort_ready: got ready=%b busy=%b expected 1 0", in_ready, busy);
    end
    do_accept(32'h1234_5678, 1'b1, ok);
    wait_done(edges);
    checks++;
    if (edges != W || out_number !== 32'hEDCB_A988) begin
      errors++;
      $display("[TB] FAIL after_abort: got %h in %0d edges expected edcba988 in %0d",
               out_number, edges, W);
    end
    // Reset while a finished result is waiting.
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_number !== '0) begin
      errors++;
      $display("[TB] FAIL done_abort: got valid=%b num=%h expected 0 0", out_valid, out_number);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a  = $urandom;
    logic [W-1:0] b  = $urandom;
    logic         ma = 1'b1;
    logic         mb = 1'b0;
    int           guard = 0;
    int           edges;
    in_valid  = 1'b1;
    in_number = a;
    mode      = ma;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_number = b;
    mode      = mb;
    wait_done(edges);
    checks++;
    if (out_number !== ref_result(a, ma)) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h expected %h", out_number, ref_result(a, ma));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_gap: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(edges);
    checks++;
    if (edges != W || out_number !== ref_result(b, mb)) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h in %0d edges expected %h in %0d",
               out_number, edges, ref_result(b, mb), W);
    end
    consume();
  endtask

  task automatic test_random();
    logic [W-1:0] n;
    logic         m;
    bit           ok;
    int           edges;
    for (int i = 0; i < 20; i++) begin
      n = $urandom;
      m = 1'($urandom);
      if (i == 0) n = 32'h8000_0000;
      do_accept(n, m, ok);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_number !== '0) begin
        errors++;
        $display("[TB] FAIL rnd%0d_shift: got busy=%b ready=%b valid=%b num=%h expected 1 0 0 0",
                 i, busy, in_ready, out_valid, out_number);
      end
      wait_done(edges);
      checks++;
      if (out_valid !== 1'b1 || out_number !== ref_result(n, m)) begin
        errors++;
        $display("[TB] FAIL rnd%0d_result: op=%h mode=%b got %h expected %h",
                 i, n, m, out_number, ref_result(n, m));
      end
`ifdef SERIAL_NEGATE_OVF_EN
      checks++;
      if (ovf !== ref_ovf(n, m)) begin
        errors++;
        $display("[TB] FAIL rnd%0d_ovf: got %b expected %b", i, ovf, ref_ovf(n, m));
      end
`endif
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_negate_32b.md
SERIAL_NEGATE_32B -- requirements
Module: serial_negate_32b

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port in_number  input  WIDTH  operand, sampled on accept.
REQ-007 SHALL have port mode  input  1  sampled on accept; 0 = one's complement (bitwise flip), 1 = two's complement negate.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_number  output  WIDTH  result.
REQ-011 SHALL have port busy  output  1  high in SHIFT state.
REQ-012 SHALL have port ovf  output  1  negate overflow flag (present only with the macro in REQ-027).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state==SHIFT).
REQ-014 Accept: in_valid && in_ready at a rising edge SHALL latch in_number and mode, clear bit counter and seen_one flag, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL process exactly one bit, LSB first, at index = counter, then increment the counter.
REQ-016 Bit rule, mode 0: result bit = NOT operand bit.
REQ-017 Bit rule, mode 1: result bit = operand bit while seen_one==0, else NOT operand bit; seen_one sets after the first processed 1 bit.
REQ-018 The edge processing bit WIDTH-1 SHALL move to DONE; out_valid first high exactly WIDTH edges after the accept edge.
REQ-019 In DONE, out_number (and ovf) SHALL be held stable while out_ready is low, for any number of cycles.
REQ-020 out_valid && out_ready at an edge SHALL return to IDLE; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-021 in_valid, in_number and mode changes while not in IDLE SHALL be ignored.
REQ-022 out_number SHALL be 0 in IDLE and SHIFT; a result is only visible in DONE.
REQ-023 Mode 1, operand 0: result 0; operand 2^(WIDTH-1): result equals operand.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter 0, seen_one 0, operand register 0, out_number 0, ovf 0, regardless of clk.
REQ-025 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation; no partial result is ever presented.
REQ-026 After rst_n deasserts, in_ready SHALL be high on the first edge.

Configuration
REQ-027 Macro SERIAL_NEGATE_OVF_EN defined: ovf port exists; in DONE ovf = 1 iff mode==1 and operand == 2^(WIDTH-1), else 0; cleared on leaving DONE.
REQ-028 Macro undefined: ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/SHIFT/DONE), default WIDTH constant, and mode encodings (MODE_FLIP=0, MODE_NEG=1).
REQ-030 One sub-module neg_bit_cell SHALL implement REQ-016/017 for one bit: inputs bit, mode, seen_one; outputs result bit, next seen_one.
REQ-031 Counter width SHALL be clog2(WIDTH); the result SHALL be built in a WIDTH-bit shift/index register, no combinational WIDTH-bit adder.

Verification
REQ-032 mode 0, in_number 0x0000_0000 -> out_number 0xFFFF_FFFF, out_valid rising exactly 32 edges after accept.
REQ-033 mode 1, in_number 0x0000_0001 -> 0xFFFF_FFFF; 0x0000_0000 -> 0x0000_0000; 0x0000_0A50 -> 0xFFFF_F5B0.
REQ-034 mode 1, in_number 0x8000_0000 with SERIAL_NEGATE_OVF_EN -> out_number 0x8000_0000, ovf 1; 0x7FFF_FFFF -> 0x8000_0001, ovf 0.
REQ-035 out_ready held low 5 cycles in DONE -> out_number/out_valid stable; in_valid pulsed during SHIFT/DONE -> ignored, result unchanged.
REQ-036 rst_n pulsed low at SHIFT counter 10 -> all outputs 0 immediately, in_ready 1 after release; new operand 0x1234_5678 mode 1 -> 0xEDCB_A988.
REQ-037 Back-to-back: two operands with in_valid held high -> second accepted one cycle after first handshake; both results correct.
